// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl -- byte-addressable synchronous data RAM with a request/response
// controller, placed directly after the core's data memory stage.
//
// Stores commit on the accept edge. Loads return after RD_LATENCY cycles as a
// one-cycle rd_valid_o pulse, with the data right-justified to bit 0.
// Misaligned, badly encoded or out-of-range accesses are dropped (stores) or
// answered with zero data (loads), and err_o is pulsed.
//
// Ports:
//   clk         core clock, rising edge
//   reset_n     asynchronous active-low reset
//   req_i       request valid; sampled only when ready_o is high
//   addr_i      byte address
//   byte_en_i   access size: BYTE / HALF_WORD / WORD; the fourth code is illegal
//   wr_i        1 = store, 0 = load
//   wr_data_i   store data, right-justified
//   ready_o     a request can be accepted this cycle
//   rd_valid_o  one-cycle pulse; rd_data_o carries the load result
//   rd_data_o   load data, right-justified, upper bits zero; held between responses
//   err_o       one-cycle pulse flagging an illegal access
module data_ram_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,  // power of two, at least 2
  parameter int unsigned RD_LATENCY  = 1      // 1..4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  byte_en_i,
  input  logic        wr_i,
  input  logic [31:0] wr_data_i,
  output logic        ready_o,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        err_o
);

  // Access-size encodings shared with the core's riscv_pkg.
  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [1:0]  CNT_INIT  = 2'(RD_LATENCY - 1);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [1:0]      rd_off_q, rd_off_d;
  logic [1:0]      rd_size_q, rd_size_d;
  logic            rd_err_q, rd_err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            illegal;
  logic [AW-1:0]   word_idx;
  logic [3:0]      lane_we;
  logic [31:0]     wr_lanes;
  logic [31:0]     rd_shift;
  logic [31:0]     rd_fmt;

  assign ready_o    = (state_q == IDLE);
  assign accept     = req_i & ready_o;
  assign word_idx   = addr_i[AW+1:2];
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign err_o      = err_q;

  // Request decode: legality and byte-lane strobes for the incoming access.
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    illegal  = 1'b0;
    lane_we  = 4'b0000;
    wr_lanes = wr_data_i;
    case (byte_en_i)
      BYTE: begin
        lane_we  = 4'b0001 << addr_i[1:0];
        wr_lanes = {4{wr_data_i[7:0]}};
      end
      HALF_WORD: begin
        illegal  = addr_i[0];
        lane_we  = addr_i[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_data_i[15:0]}};
      end
      WORD: begin
        illegal  = (addr_i[1:0] != 2'b00);
        lane_we  = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
    // No aliasing: anything past the last word is an error.
    if (addr_i[31:2] >= DEPTH_LIM) illegal = 1'b1;
  end

  // Store port: legal stores commit on the accept edge, only the strobed lanes.
  // NOTE: the array has no reset; contents are undefined until written, which
  // keeps it mappable onto a RAM macro.
  always_ff @(posedge clk) begin
    if (accept && wr_i && !illegal) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_we[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Load formatting from the captured request: shift the addressed lane to
  // bit 0 and zero everything above the access size.
  always_comb begin
    rd_shift = mem[rd_idx_q] >> {rd_off_q, 3'b000};
    case (rd_size_q)
      BYTE:      rd_fmt = {24'h0, rd_shift[7:0]};
      HALF_WORD: rd_fmt = {16'h0, rd_shift[15:0]};
      default:   rd_fmt = rd_shift;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    rd_off_d   = rd_off_q;
    rd_size_d  = rd_size_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr_i) begin
            err_d = illegal;
          end else begin
            state_d   = RD_WAIT;
            cnt_d     = CNT_INIT;
            rd_idx_d  = word_idx;
            rd_off_d  = addr_i[1:0];
            rd_size_d = byte_en_i;
            rd_err_d  = illegal;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          // Response cycle: ready_o rises together with rd_valid_o, so a
          // waiting request is taken on the edge that ends this cycle.
          state_d    = IDLE;
          rd_valid_d = 1'b1;
          err_d      = rd_err_q;
          rd_data_d  = rd_err_q ? 32'h0 : rd_fmt;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      rd_idx_q   <= '0;
      rd_off_q   <= 2'd0;
      rd_size_q  <= 2'd0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      rd_off_q   <= rd_off_d;
      rd_size_q  <= rd_size_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl. Three instances differ only in RD_LATENCY
// (1, 3, 4); each has its own request signals and shares clock and reset.
module tb_data_ram_ctrl;

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;
  localparam logic [1:0] BAD_SIZE  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [2:0]  req = '0;
  logic [2:0]  wr = '0;
  logic [31:0] addr [3];
  logic [1:0]  ben [3];
  logic [31:0] wdata [3];
  logic [2:0]  ready;
  logic [2:0]  rd_valid;
  logic [2:0]  err;
  logic [31:0] rd_data [3];

  int lat [3] = '{1, 3, 4};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.DEPTH_WORDS(1024), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .req_i(req[0]), .addr_i(addr[0]),
    .byte_en_i(ben[0]), .wr_i(wr[0]), .wr_data_i(wdata[0]), .ready_o(ready[0]),
    .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]), .err_o(err[0]));

  data_ram_ctrl #(.DEPTH_WORDS(1024), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .req_i(req[1]), .addr_i(addr[1]),
    .byte_en_i(ben[1]), .wr_i(wr[1]), .wr_data_i(wdata[1]), .ready_o(ready[1]),
    .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]), .err_o(err[1]));

  data_ram_ctrl #(.DEPTH_WORDS(1024), .RD_LATENCY(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .req_i(req[2]), .addr_i(addr[2]),
    .byte_en_i(ben[2]), .wr_i(wr[2]), .wr_data_i(wdata[2]), .ready_o(ready[2]),
    .rd_valid_o(rd_valid[2]), .rd_data_o(rd_data[2]), .err_o(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One store; err_o is checked in the cycle after the accept edge.
  task automatic do_write(input int d, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] data, input logic exp_err, input string tag);
    @(negedge clk);
    check({tag, "_rdy"}, 32'(ready[d]), 32'd1);
    check({tag, "_err_idle"}, 32'(err[d]), 32'd0);
    req[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; ben[d] = sz; wdata[d] = data;
    @(negedge clk);
    req[d] = 1'b0; wr[d] = 1'b0;
    check({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    check({tag, "_rdy_after"}, 32'(ready[d]), 32'd1);
  endtask

  // One load; checks latency, data, err and that the response is a one-cycle
  // pulse with data held afterwards.
  task automatic do_read(input int d, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] exp_data, input logic exp_err, input string tag);
    int n;
    int early_err;
    bit got;
    n = 0; early_err = 0; got = 1'b0;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(ready[d]), 32'd1);
    req[d] = 1'b1; wr[d] = 1'b0; addr[d] = a; ben[d] = sz;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      req[d] = 1'b0;
      if (rd_valid[d]) got = 1'b1;
      else begin
        n++;
        if (err[d]) early_err++;
      end
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"}, n, lat[d]);
      check({tag, "_data"}, rd_data[d], exp_data);
      check({tag, "_err"}, 32'(err[d]), 32'(exp_err));
      check({tag, "_rdy_resp"}, 32'(ready[d]), 32'd1);
      check({tag, "_early_err"}, early_err, 0);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(rd_valid[d]), 32'd0);
      check({tag, "_hold"}, rd_data[d], exp_data);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; ben[d] = WORD; wdata[d] = '0;
    end

    // Reset values, then release away from the active edge.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd1);
      check($sformatf("rst_valid%0d", d), 32'(rd_valid[d]), 32'd0);
      check($sformatf("rst_data%0d", d), rd_data[d], 32'h0);
      check($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
    end

    // RD_LATENCY=1: word write/read, then byte and half-word lanes.
    do_write(0, 32'h10, WORD, 32'hDEADBEEF, 1'b0, "w_word");
    do_read (0, 32'h10, WORD, 32'hDEADBEEF, 1'b0, "r_word");
    do_write(0, 32'h12, BYTE, 32'hFFFFFF5A, 1'b0, "w_byte");
    do_read (0, 32'h10, WORD, 32'hDE5ABEEF, 1'b0, "r_word2");
    do_read (0, 32'h13, BYTE, 32'h000000DE, 1'b0, "r_byte3");
    do_read (0, 32'h12, HALF_WORD, 32'h0000DE5A, 1'b0, "r_half2");
    do_read (0, 32'h11, BYTE, 32'h000000BE, 1'b0, "r_byte1");

    // Misaligned and badly encoded accesses.
    do_write(0, 32'h11, WORD, 32'h12345678, 1'b1, "w_misal");
    do_read (0, 32'h10, WORD, 32'hDE5ABEEF, 1'b0, "r_unchanged");
    do_read (0, 32'h13, HALF_WORD, 32'h0, 1'b1, "r_half_misal");
    do_read (0, 32'h10, BAD_SIZE, 32'h0, 1'b1, "r_bad_size");
    do_write(0, 32'h10, BAD_SIZE, 32'h0, 1'b1, "w_bad_size");

    // Half-word store into the low lanes.
    do_write(0, 32'h10, HALF_WORD, 32'hFFFF1234, 1'b0, "w_half0");
    do_read (0, 32'h10, WORD, 32'hDE5A1234, 1'b0, "r_word3");

    // Range limits: last word is legal, first word past the end is not, and
    // an out-of-range store must not alias onto word 0.
    do_read (0, 32'h1000, WORD, 32'h0, 1'b1, "r_oor");
    do_write(0, 32'hFFC, WORD, 32'hCAFEF00D, 1'b0, "w_last");
    do_read (0, 32'hFFC, WORD, 32'hCAFEF00D, 1'b0, "r_last");
    do_write(0, 32'h0, WORD, 32'h11111111, 1'b0, "w_zero");
    do_write(0, 32'h1000, WORD, 32'h22222222, 1'b1, "w_oor");
    do_read (0, 32'h0, WORD, 32'h11111111, 1'b0, "r_no_alias");

    // RD_LATENCY=3 with req_i held high; the address changes while the
    // controller is busy and must only be picked up on the second acceptance.
    do_write(1, 32'h10, WORD, 32'h0BADF00D, 1'b0, "l3_w0");
    do_write(1, 32'h14, WORD, 32'h55AA55AA, 1'b0, "l3_w1");
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h10; ben[1] = WORD;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check($sformatf("l3_ready_c%0d", n), 32'(ready[1]),
            32'((n == 3) || (n == 7)));
      check($sformatf("l3_valid_c%0d", n), 32'(rd_valid[1]),
            32'((n == 3) || (n == 7)));
      if (n == 0) addr[1] = 32'h14;
      if (n == 3) check("l3_data_first", rd_data[1], 32'h0BADF00D);
      if (n == 4) req[1] = 1'b0;
      if (n == 7) check("l3_data_second", rd_data[1], 32'h55AA55AA);
    end

    // RD_LATENCY=4: normal read, then a read aborted by reset.
    do_write(2, 32'h10, WORD, 32'hA5A5C3C3, 1'b0, "l4_w");
    do_read (2, 32'h10, WORD, 32'hA5A5C3C3, 1'b0, "l4_r");
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h10; ben[2] = WORD;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(ready[2]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready[2]), 32'd1);
    check("abort_valid", 32'(rd_valid[2]), 32'd0);
    check("abort_data", rd_data[2], 32'h0);
    check("abort_err", 32'(err[2]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("abort_post_valid%0d", n), 32'(rd_valid[2]), 32'd0);
      check($sformatf("abort_post_ready%0d", n), 32'(ready[2]), 32'd1);
    end
    do_read (2, 32'h10, WORD, 32'hA5A5C3C3, 1'b0, "l4_r_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
